// File: rtl/uart_rx.sv
// uart_rx -- UART receiver: 8 data bits, LSB first, one stop bit, idle-high line.
//
// Ports
//   i_Clock          system clock, all logic on the rising edge
//   i_Rst_L          asynchronous active-low reset
//   i_Rx_Serial      asynchronous serial input (idle high)
//   o_Rx_Dv          one-cycle pulse: o_Rx_Byte holds a newly received byte
//   o_Rx_Byte        last validly received byte
//   o_Rx_Active      high from a validated start bit until the frame is finished
//   o_Rx_Frame_Err   one-cycle pulse: stop bit sampled low
//   o_Rx_Parity_Err  one-cycle pulse: even-parity mismatch (parity build only)
//
// Parameter
//   CLKS_PER_BIT     i_Clock cycles per serial bit, 4..65535
//
// Build option
//   UART_RX_PARITY_EN  when defined, an even parity bit is expected between the
//                      last data bit and the stop bit. When undefined the frame
//                      is plain 8N1 and o_Rx_Parity_Err stays 0.

module uart_rx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_Dv,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Active,
  output logic       o_Rx_Frame_Err,
  output logic       o_Rx_Parity_Err
);

  // Terminal counts: a full bit is counter values 0..BIT_LAST, the start-bit
  // check lands near the middle of the start bit at HALF_LAST.
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    CLEANUP = 3'd5
  } state_t;

  state_t      state;
  logic [15:0] clk_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        rx_meta;
  logic        rx_s;
`ifdef UART_RX_PARITY_EN
  logic        par_bit;
`endif

  // Even parity: data bits plus parity bit must hold an even number of ones.
  function automatic logic parity_bad(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  // Two-flop synchronizer; resets to the idle (high) level so reset never
  // looks like a start edge.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_Rx_Serial;
      rx_s    <= rx_meta;
    end
  end

  // Receive state machine with registered status outputs.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state           <= IDLE;
      clk_cnt         <= 16'd0;
      bit_idx         <= 3'd0;
      shift           <= 8'h00;
      o_Rx_Byte       <= 8'h00;
      o_Rx_Dv         <= 1'b0;
      o_Rx_Active     <= 1'b0;
      o_Rx_Frame_Err  <= 1'b0;
      o_Rx_Parity_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit         <= 1'b0;
`endif
    end else begin
      // Status pulses last exactly one cycle unless set again below.
      o_Rx_Dv         <= 1'b0;
      o_Rx_Frame_Err  <= 1'b0;
      o_Rx_Parity_Err <= 1'b0;

      case (state)
        IDLE: begin
          clk_cnt <= 16'd0;
          bit_idx <= 3'd0;
          if (!rx_s) begin
            state <= START;
          end else begin
            state <= IDLE;
          end
        end

        START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= 16'd0;
            // Still low mid-bit: a real start bit. High again: a glitch.
            if (!rx_s) begin
              state       <= DATA;
              o_Rx_Active <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end

        DATA: begin
          if (clk_cnt < BIT_LAST) begin
            clk_cnt <= clk_cnt + 16'd1;
          end else begin
            clk_cnt         <= 16'd0;
            shift[bit_idx]  <= rx_s;
            if (bit_idx == 3'd7) begin
              bit_idx <= 3'd0;
`ifdef UART_RX_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (clk_cnt < BIT_LAST) begin
            clk_cnt <= clk_cnt + 16'd1;
          end else begin
            clk_cnt <= 16'd0;
            par_bit <= rx_s;
            state   <= STOP;
          end
        end
`endif

        STOP: begin
          if (clk_cnt < BIT_LAST) begin
            clk_cnt <= clk_cnt + 16'd1;
          end else begin
            clk_cnt <= 16'd0;
            state   <= CLEANUP;
            // A framing error outranks a parity error; a bad frame never
            // overwrites the last good byte.
            if (!rx_s) begin
              o_Rx_Frame_Err <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (parity_bad(shift, par_bit)) begin
              o_Rx_Parity_Err <= 1'b1;
`endif
            end else begin
              o_Rx_Byte <= shift;
              o_Rx_Dv   <= 1'b1;
            end
          end
        end

        CLEANUP: begin
          o_Rx_Active <= 1'b0;
          clk_cnt     <= 16'd0;
          bit_idx     <= 3'd0;
          // A stuck-low (break) line waits here rather than retriggering.
          if (rx_s) begin
            state <= IDLE;
          end else begin
            state <= CLEANUP;
          end
        end

        default: begin
          state       <= IDLE;
          clk_cnt     <= 16'd0;
          bit_idx     <= 3'd0;
          o_Rx_Active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- randomized self-checking bench for uart_rx (CLKS_PER_BIT = 8).
// Frames are serialized from byte values; a frame-level model predicts the
// event (good byte / framing error / parity error) each frame must produce
// and the byte register value that follows it.

module tb_uart_rx;

  localparam int C = 8;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 10;
`else
  localparam int NBITS = 9;
`endif

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       dv;
  logic [7:0] rx_byte;
  logic       active;
  logic       ferr;
  logic       perr;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .i_Clock        (clk),
    .i_Rst_L        (rst_n),
    .i_Rx_Serial    (rx),
    .o_Rx_Dv        (dv),
    .o_Rx_Byte      (rx_byte),
    .o_Rx_Active    (active),
    .o_Rx_Frame_Err (ferr),
    .o_Rx_Parity_Err(perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;
  int unsigned multi_cnt = 0;
  int unsigned act_cnt   = 0;
  int unsigned start_cyc = 0;
  int          obs_rd    = 0;

  // Event encoding: {kind, byte}; kind 1 = good byte, 2 = frame err, 3 = parity err.
  logic [9:0]  exp_q[$];
  logic [9:0]  obs_q[$];
  int unsigned obs_cyc_q[$];
  logic [7:0]  model_byte;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Record every status pulse seen by the outside world.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dv)   begin obs_q.push_back({2'd1, rx_byte}); obs_cyc_q.push_back(cyc); end
      if (ferr) begin obs_q.push_back({2'd2, rx_byte}); obs_cyc_q.push_back(cyc); end
      if (perr) begin obs_q.push_back({2'd3, rx_byte}); obs_cyc_q.push_back(cyc); end
      if ((32'(dv) + 32'(ferr) + 32'(perr)) > 32'd1) multi_cnt <= multi_cnt + 1;
      if (active) act_cnt <= act_cnt + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    tick(C);
  endtask

  // Serialize one frame and queue the event it must cause.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok,
                            input int low_hold);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_ok ? ^b : ~^b);
`endif
    if (stop_ok) begin
      drive_bit(1'b1);
      if (par_ok) begin
        model_byte = b;
        exp_q.push_back({2'd1, b});
      end else begin
        exp_q.push_back({2'd3, model_byte});
      end
    end else begin
      drive_bit(1'b0);
      tick(low_hold);
      check("no_restart_while_low", {31'd0, active}, 32'd0);
      exp_q.push_back({2'd2, model_byte});
      rx = 1'b1;
      tick(C);
    end
  endtask

  task automatic wait_obs(input int n);
    int waited = 0;
    while ((obs_q.size() - obs_rd) < n && waited < 40 * C) begin
      tick(1);
      waited++;
    end
  endtask

  // Compare all observed events against the predicted ones, in order.
  task automatic drain(input string tag);
    int n_obs;
    wait_obs(exp_q.size());
    tick(2 * C);
    n_obs = obs_q.size() - obs_rd;
    check({tag, "_count"}, n_obs, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < n_obs) check({tag, "_event"}, obs_q[obs_rd + i], exp_q[i]);
    end
    obs_rd = obs_q.size();
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  b;
    logic [7:0]  c3;
    int unsigned act0;
    int          lat;
    int          lat_exp;
    bit          stop_ok;
    bit          par_ok;

    rx         = 1'b1;
    rst_n      = 1'b0;
    model_byte = 8'h00;
    tick(3);
    check("rst_byte",   {24'd0, rx_byte}, 32'h00);
    check("rst_dv",     {31'd0, dv},      32'd0);
    check("rst_active", {31'd0, active},  32'd0);
    check("rst_ferr",   {31'd0, ferr},    32'd0);
    check("rst_perr",   {31'd0, perr},    32'd0);
    rst_n = 1'b1;
    tick(2 * C);

    // Single frame, with latency from start edge to the byte-valid pulse.
    act0 = act_cnt;
    send_frame(8'h37, 1'b1, 1'b1, 0);
    wait_obs(1);
    lat_exp = 2 + (C - 1) / 2 + NBITS * C + 1;
    if ((obs_q.size() - obs_rd) > 0) begin
      lat = int'(obs_cyc_q[obs_rd] - start_cyc);
      check("latency", (lat >= lat_exp - 1 && lat <= lat_exp + 1) ? lat_exp : lat, lat_exp);
    end else begin
      check("latency_pulse_seen", 32'd0, 32'd1);
    end
    drain("frame37");
    check("byte37",         {24'd0, rx_byte}, 32'h37);
    check("active_after37", {31'd0, active},  32'd0);
    check("active_seen37",  {31'd0, act_cnt != act0}, 32'd1);

    // Back-to-back frames with a single stop bit each.
    send_frame(8'h00, 1'b1, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 1'b1, 0);
    send_frame(8'hA5, 1'b1, 1'b1, 0);
    drain("b2b");
    check("byte_b2b", {24'd0, rx_byte}, 32'hA5);

    // Two-cycle low glitch on an idle line.
    act0 = act_cnt;
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(3 * C);
    drain("glitch");
    check("glitch_no_active", act_cnt - act0, 32'd0);

    // Stop bit low with the line stuck low afterwards.
    send_frame(8'h5A, 1'b0, 1'b1, 40);
    drain("frame_err");
    check("byte_after_ferr", {24'd0, rx_byte}, {24'd0, model_byte});

    // Reset in the middle of bit 4 of 0xC3, then a clean 0x12.
    c3 = 8'hC3;
    rx = 1'b0;
    tick(C);
    for (int i = 0; i < 4; i++) drive_bit(c3[i]);
    rx = c3[4];
    tick(C / 2);
    check("active_mid_frame", {31'd0, active}, 32'd1);
    rst_n = 1'b0;
    tick(1);
    check("rst_mid_active", {31'd0, active},  32'd0);
    check("rst_mid_byte",   {24'd0, rx_byte}, 32'h00);
    model_byte = 8'h00;
    tick(2);
    rx    = 1'b1;
    rst_n = 1'b1;
    tick(2 * C);
    drain("reset_abort");
    send_frame(8'h12, 1'b1, 1'b1, 0);
    drain("after_reset");
    check("byte12", {24'd0, rx_byte}, 32'h12);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 0);
    send_frame(8'h07, 1'b1, 1'b1, 0);
    drain("parity07");
    check("byte07", {24'd0, rx_byte}, 32'h07);
`endif

    // Randomized frames: mixed data, occasional bad stop/parity, random gaps.
    for (int f = 0; f < 24; f++) begin
      b       = 8'($urandom_range(0, 255));
      stop_ok = ($urandom_range(0, 4) != 0);
`ifdef UART_RX_PARITY_EN
      par_ok  = ($urandom_range(0, 3) != 0);
`else
      par_ok  = 1'b1;
`endif
      send_frame(b, stop_ok, par_ok, int'($urandom_range(0, 3 * C)));
      rx = 1'b1;
      tick(int'($urandom_range(0, C)));
      if ((f % 4) == 3) drain("random");
    end
    drain("random_tail");
    check("byte_final",   {24'd0, rx_byte}, {24'd0, model_byte});
    check("active_final", {31'd0, active},  32'd0);
    check("single_pulse", multi_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, meaning i_Clock cycles per serial bit; legal range 4..65535.
REQ-002 SHALL have port i_Clock  input  1  the single system clock; all logic on its rising edge.
REQ-003 SHALL have port i_Rst_L  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_Rx_Serial  input  1  asynchronous serial line; idle high; 8N1 frames, LSB first.
REQ-005 SHALL have port o_Rx_Dv  output  1  one-cycle pulse: o_Rx_Byte holds a newly received valid byte.
REQ-006 SHALL have port o_Rx_Byte  output  8  last validly received byte.
REQ-007 SHALL have port o_Rx_Active  output  1  high from validated start bit until return to IDLE.
REQ-008 SHALL have port o_Rx_Frame_Err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 SHALL have port o_Rx_Parity_Err  output  1  one-cycle pulse: parity mismatch (see Configuration).

Function
REQ-010 SHALL pass i_Rx_Serial through a two-flop synchronizer; all decisions use the second-stage output (rx_s); added input latency 2 cycles.
REQ-011 SHALL implement states IDLE, START, DATA, [PARITY], STOP, CLEANUP; any unencoded state SHALL go to IDLE next cycle.
REQ-012 IDLE: clock counter and bit index held at 0; rx_s low -> START.
REQ-013 START: count to (CLKS_PER_BIT-1)/2 (integer division); at terminal count rx_s low -> DATA with counter cleared and o_Rx_Active set; rx_s high -> IDLE (glitch rejected, no output pulse).
REQ-014 DATA: count CLKS_PER_BIT-1 cycles, then sample rx_s into shift data bit [index], index 0 first; after index 7 -> STOP (or PARITY), index wraps to 0.
REQ-015 STOP: count CLKS_PER_BIT-1 cycles, then sample rx_s; high -> o_Rx_Byte loaded and o_Rx_Dv pulsed; low -> o_Rx_Frame_Err pulsed, o_Rx_Byte unchanged; either case -> CLEANUP.
REQ-016 o_Rx_Dv, o_Rx_Frame_Err, o_Rx_Parity_Err SHALL be registered and high for exactly one cycle, the cycle after the stop-bit sample; never two of them simultaneously.
REQ-017 CLEANUP: o_Rx_Active cleared; remain until rx_s high (break/stuck-low line does not retrigger START), then -> IDLE.
REQ-018 Clock counter SHALL be 16 bits; comparisons use CLKS_PER_BIT-1 without overflow.
REQ-019 A start edge arriving while in CLEANUP with rx_s already high SHALL be accepted from IDLE the following cycle (back-to-back frames with one stop bit SHALL be received without loss).
REQ-020 Total latency, falling start edge at pin to o_Rx_Dv: 2 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT + 1 cycles, +/-1.

Reset
REQ-021 i_Rst_L low SHALL asynchronously force: state IDLE, counter 0, index 0, synchronizer flops 1, o_Rx_Byte 0x00, o_Rx_Dv 0, o_Rx_Active 0, o_Rx_Frame_Err 0, o_Rx_Parity_Err 0.
REQ-022 Reset asserted mid-frame SHALL discard the partial byte; after release, reception resumes only at the next falling edge following rx_s high.

Configuration
REQ-023 Macro UART_RX_PARITY_EN defined: PARITY state inserted after DATA, counts CLKS_PER_BIT-1 and samples an even parity bit; mismatch at stop sample time pulses o_Rx_Parity_Err instead of o_Rx_Dv (frame error takes priority), o_Rx_Byte unchanged.
REQ-024 Macro UART_RX_PARITY_EN undefined: no PARITY state, 8N1 framing, o_Rx_Parity_Err tied 0.

Verification (CLKS_PER_BIT=8 unless stated)
REQ-025 Frame 0x37 with valid stop -> o_Rx_Dv one-cycle pulse, o_Rx_Byte=0x37, o_Rx_Active low after.
REQ-026 Back-to-back 0x00, 0xFF, 0xA5 with single stop bits -> three o_Rx_Dv pulses, bytes in order, none lost.
REQ-027 Low glitch of 2 cycles on idle line -> return to IDLE, no o_Rx_Dv, no o_Rx_Active.
REQ-028 Frame 0x5A with stop bit low, line held low 40 cycles -> o_Rx_Frame_Err pulse, o_Rx_Byte keeps prior value, no restart until line high.
REQ-029 i_Rst_L pulsed low during bit 4 of 0xC3, then frame 0x12 -> no pulse for 0xC3, o_Rx_Byte=0x12.
REQ-030 With UART_RX_PARITY_EN, 0x07 sent with parity bit 0 -> o_Rx_Parity_Err pulse, no o_Rx_Dv; with parity bit 1 -> o_Rx_Dv, byte 0x07.
